// File: rtl/exp_ctrl_pkg.sv
// rtl/exp_ctrl_pkg.sv - shared state type and constants for the exp stage controller
package exp_ctrl_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;
  localparam int CNT_W_DEFAULT = 10;
  localparam int LATENCY = 2;
endpackage

// File: rtl/exp_pipe_valid.sv
// rtl/exp_pipe_valid.sv - occupancy bits and stage enables for the two-stage exp datapath
module exp_pipe_valid #(
  parameter int LATENCY = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  input  logic issue_ok,
  input  logic in_valid,
  input  logic out_ready,
  output logic in_ready,
  output logic stage_run2,
  output logic stage_run,
  output logic out_valid
);
  // occ[1] marks the first register stage, occ[0] the output stage
  logic [LATENCY-1:0] occ;

  assign stage_run  = occ[1] && (!occ[0] || out_ready);
  assign in_ready   = issue_ok && (!occ[1] || stage_run);
  assign stage_run2 = in_valid && in_ready;
  assign out_valid  = occ[0];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      occ <= '0;
    end else begin
      occ[1] <= stage_run2 ? 1'b1 : (stage_run ? 1'b0 : occ[1]);
      occ[0] <= stage_run ? 1'b1 : (out_ready ? 1'b0 : occ[0]);
    end
  end
endmodule

// File: rtl/exp_stage_ctrl.sv
// rtl/exp_stage_ctrl.sv - job sequencer for the exp datapath pipeline
// Optional stall_cnt output enabled by EXP_CTRL_STALL_CNT_EN.
module exp_stage_ctrl
  import exp_ctrl_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEFAULT,
  parameter int LATENCY = exp_ctrl_pkg::LATENCY
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             stage_run2,
  output logic             stage_run,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic             done
`ifdef EXP_CTRL_STALL_CNT_EN
  ,output logic [31:0]     stall_cnt
`endif
);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] len_reg, in_cnt, out_cnt;
  logic             start_acc, out_hs, last_in, last_out, issue_ok;

  assign start_acc = (state == ST_IDLE) && start && !flush;
  assign out_hs    = out_valid && out_ready;
  assign issue_ok  = (state == ST_RUN) && (in_cnt < len_reg);
  assign last_in   = stage_run2 && (in_cnt == len_reg - CNT_ONE);
  assign last_out  = (out_cnt == len_reg - CNT_ONE);
  assign out_last  = out_valid && last_out;

  exp_pipe_valid #(.LATENCY(LATENCY)) u_pipe_valid (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .issue_ok   (issue_ok),
    .in_valid   (in_valid),
    .out_ready  (out_ready),
    .in_ready   (in_ready),
    .stage_run2 (stage_run2),
    .stage_run  (stage_run),
    .out_valid  (out_valid)
  );

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE:  if (start) state_nxt = (len != '0) ? ST_RUN : ST_DONE;
      ST_RUN: begin
        busy = 1'b1;
        if (last_in) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (out_hs && last_out) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default:  state_nxt = ST_IDLE;
    endcase
    // abort wins over start and any handshake in the same cycle
    if (flush) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      len_reg <= '0;
      in_cnt  <= '0;
      out_cnt <= '0;
    end else if (flush) begin
      in_cnt  <= '0;
      out_cnt <= '0;
    end else if (start_acc) begin
      len_reg <= len;
      in_cnt  <= '0;
      out_cnt <= '0;
    end else begin
      if (stage_run2) in_cnt  <= in_cnt + CNT_ONE;
      if (out_hs)     out_cnt <= out_cnt + CNT_ONE;
    end
  end

`ifdef EXP_CTRL_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (reset || start_acc) begin
      stall_cnt <= '0;
    end else if (busy && out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_exp_stage_ctrl.sv
// tb/tb_exp_stage_ctrl.sv - scoreboard bench for exp_stage_ctrl with directed and random jobs
module tb_exp_stage_ctrl;
  localparam int CNT_W = 10;

  logic clk = 1'b0;
  logic reset = 1'b1, start = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [CNT_W-1:0] len = '0;
  logic in_ready, stage_run2, stage_run, out_valid, out_last, busy, done;
`ifdef EXP_CTRL_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int tests = 0, fails = 0;
  int acc_total = 0, done_seen = 0, exp_done = 0;
  bit sb[$];

  always #5 clk = ~clk;

  exp_stage_ctrl #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .len        (len),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .stage_run2 (stage_run2),
    .stage_run  (stage_run),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done)
`ifdef EXP_CTRL_STALL_CNT_EN
    ,.stall_cnt (stall_cnt)
`endif
  );

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Job model: a job of n elements yields n results in order, only the final one flagged last.
  task automatic issue_start(input int n);
    start = 1'b1;
    len   = CNT_W'(n);
    for (int i = 0; i < n; i++) sb.push_back(i == n - 1);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (in_valid && in_ready) acc_total++;
      if (done) done_seen++;
      if (out_valid && out_ready) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL sb_unexpected: got output with out_last=%0d expected none", out_last);
        end else begin
          bit exp_last;
          exp_last = sb.pop_front();
          fails -= 0;
          tests--;
          check("sb_out_last", out_last, exp_last);
        end
      end
    end
  end

  task automatic settle();
    start = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) tick();
  endtask

  task automatic run_job(input int n, input int bound);
    int acc0, d0, cyc;
    acc0 = acc_total;
    d0   = done_seen;
    cyc  = 0;
    issue_start(n);
    exp_done++;
    tick();
    start = 1'b0;
    while (done_seen == d0 && cyc < bound) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      start     = ($urandom_range(0, 15) == 0);
      len       = CNT_W'($urandom_range(0, 20));
      tick();
      cyc++;
    end
    start = 1'b0;
    in_valid = 1'b0;
    check("job_timeout", (cyc < bound), 1);
    check("job_accepted", acc_total - acc0, n);
  endtask

  initial begin
    out_ready = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_stage_run", stage_run | stage_run2, 0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("idle_in_ready", in_ready, 0);
    check("idle_out_last", out_last, 0);
    tick();

    // len=4 streaming at full rate
    in_valid = 1'b1; out_ready = 1'b1;
    issue_start(4); exp_done++;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      check("t1_stage_run2", stage_run2, (c >= 1 && c <= 4));
      check("t1_out_valid", out_valid, (c >= 3 && c <= 6));
      check("t1_out_last", out_last, (c == 6));
      check("t1_done", done, (c == 7));
      tick();
      start = 1'b0;
    end
    settle();

    // len=3 with downstream stalled for 5 cycles after the first result
    in_valid = 1'b1; out_ready = 1'b0;
    issue_start(3); exp_done++;
    for (int c = 0; c < 13; c++) begin
      out_ready = (c >= 8);
      @(negedge clk);
      if (c >= 3 && c <= 7) begin
        check("t2_in_ready", in_ready, 0);
        check("t2_stage_run", stage_run, 0);
        check("t2_out_valid", out_valid, 1);
        check("t2_out_last", out_last, 0);
      end
      if (c >= 8) check("t2_done", done, (c == 11));
      tick();
      start = 1'b0;
    end
`ifdef EXP_CTRL_STALL_CNT_EN
    check("t2_stall_cnt", stall_cnt, 5);
`endif
    settle();

    // zero-length job
    in_valid = 1'b1;
    issue_start(0); exp_done++;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("t3_in_ready", in_ready, 0);
      check("t3_stage_run2", stage_run2, 0);
      check("t3_stage_run", stage_run, 0);
      check("t3_done", done, (c == 1));
      tick();
      start = 1'b0;
    end
    settle();

    // flush with both stages occupied
    in_valid = 1'b1; out_ready = 1'b0;
    issue_start(5);
    for (int c = 0; c < 4; c++) begin
      tick();
      start = 1'b0;
    end
    @(negedge clk);
    check("t4_full_out_valid", out_valid, 1);
    check("t4_full_in_ready", in_ready, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    sb.delete();
    @(negedge clk);
    check("t4_busy", busy, 0);
    check("t4_out_valid", out_valid, 0);
    check("t4_in_ready", in_ready, 0);
    check("t4_done", done, 0);
    tick();
    @(negedge clk);
    check("t4_done_late", done, 0);
    tick();
    run_job(2, 300);
    settle();

    // restart attempts during RUN are ignored
    begin
      int acc0, d0, cyc;
      acc0 = acc_total; d0 = done_seen; cyc = 0;
      in_valid = 1'b1; out_ready = 1'b1;
      issue_start(3); exp_done++;
      tick(); start = 1'b0;
      tick(); start = 1'b1; len = CNT_W'(7);
      tick(); start = 1'b0; len = CNT_W'(9);
      while (done_seen == d0 && cyc < 50) begin
        tick();
        cyc++;
      end
      check("t5_timeout", (cyc < 50), 1);
      check("t5_accepted", acc_total - acc0, 3);
    end
    settle();

    // reset while draining
    in_valid = 1'b1; out_ready = 1'b1;
    issue_start(3);
    for (int c = 0; c < 4; c++) begin
      tick();
      start = 1'b0;
    end
    out_ready = 1'b0; reset = 1'b1;
    @(negedge clk);
    check("t6_drain_busy", busy, 1);
    check("t6_drain_in_ready", in_ready, 0);
    tick();
    reset = 1'b0;
    sb.delete();
    @(negedge clk);
    check("t6_busy", busy, 0);
    check("t6_out_valid", out_valid, 0);
    check("t6_out_last", out_last, 0);
    check("t6_in_ready", in_ready, 0);
    check("t6_stages", stage_run | stage_run2, 0);
    check("t6_done", done, 0);
`ifdef EXP_CTRL_STALL_CNT_EN
    check("t6_stall_cnt", stall_cnt, 0);
`endif
    tick();
    settle();

    for (int j = 0; j < 20; j++) begin
      run_job($urandom_range(0, 12), 600);
      settle();
    end

    check("done_count", done_seen, exp_done);
    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
